next_pc_mux: RTL and testbench
==============================

Name: next_pc_mux

Overview:
- Next-PC selection stage of the single-cycle (monocycle) RISC-V-style processor.
- Chooses between the sequential address (PC+4) and the branch/jump target, driven by the branch-decision select.
- Presents the selection combinationally as next_pc.
- Also holds the architectural PC register, which loads next_pc each enabled clock edge.

Parameters:
- XLEN, 32, address width in bits.
- RESET_PC, 32'h0000_0000, value loaded into the PC register while reset is asserted.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- pc_plus4  input  XLEN  sequential address (current PC + 4), computed upstream.
- branch_target  input  XLEN  taken-branch/jump target address.
- sel  input  1  0 = sequential (pc_plus4), 1 = branch (branch_target).
- pc_en  input  1  PC register load enable; 0 = hold current PC (stall).
- next_pc  output  XLEN  selected next address, combinational.
- pc  output  XLEN  registered program counter.
- next_pc_misaligned  output  1  high when next_pc[1:0] != 2'b00, combinational.

Behaviour:
- next_pc = sel ? branch_target : pc_plus4.
  - Purely combinational, zero latency, no arithmetic.
  - Must settle within the same cycle as any input change.
- Values are treated as unsigned bit vectors:
  - No sign extension, no modification, no masking of low bits.
  - All XLEN bits pass through unchanged (e.g. 32'h1000_0000 and 32'h0000_0000 pass verbatim).
- sel of X/Z is not a supported input. The implementation need not define next_pc in that case; synthesis treats it as don't-care.
- next_pc does not depend on clk or rst_n; it is valid during reset as well.
- PC register:
  - rst_n low: pc = RESET_PC immediately (asynchronous), held while rst_n is low.
  - Rising edge of clk with rst_n high and pc_en = 1: pc <= next_pc.
  - Rising edge with pc_en = 0: pc holds its value.
- Reset deassertion: the first enabled edge after rst_n rises loads next_pc. Reset assertion mid-operation overrides any pending load.
- next_pc_misaligned = |next_pc[1:0].
  - Informational only; the PC still loads the misaligned value.
  - Trap handling is the responsibility of the control unit.
- Edge cases:
  - Backward branch (branch_target < pc_plus4): no special handling.
  - Wrap-around at address 0: no special handling; values are forwarded as-is.
  - Branch to address 0: no special handling.

Decomposition:
- Shared package (processor-wide):
  - XLEN constant.
  - RESET_PC constant.
  - Enumerated type for the PC-source select (PC_SRC_SEQ = 0, PC_SRC_BRANCH = 1).
- Sub-module pc_reg: the XLEN-bit enable flop with asynchronous active-low reset.
- The mux itself stays inline in next_pc_mux.

Test Plan:
1. sel=0, pc_plus4=32'h0000_0004, branch_target=32'h0000_1000 -> next_pc=32'h0000_0004 after 10 ns settle; next_pc_misaligned=0.
2. sel=1, pc_plus4=32'h0000_0008, branch_target=32'h0000_1000 -> next_pc=32'h0000_1000. Also sel=1, pc_plus4=32'h0000_0204, branch_target=32'h0000_0100 (backward) -> next_pc=32'h0000_0100.
3. Full-width pass-through:
   - sel=0, pc_plus4=32'h0FFF_FFF4 -> next_pc=32'h0FFF_FFF4.
   - sel=1, branch_target=32'h1000_0000 -> next_pc=32'h1000_0000.
   - sel=1, branch_target=0, pc_plus4=32'h0000_0ABC -> next_pc=0.
   - sel=0, pc_plus4=0, branch_target=32'h0000_0500 -> next_pc=0.
4. Reset:
   - Drive rst_n=0 between clock edges -> pc=RESET_PC immediately.
   - Release rst_n, pc_en=1, sel=0, pc_plus4=32'h0000_0004 -> pc=32'h0000_0004 after the next rising edge.
5. Stall: pc=32'h0000_0100, pc_en=0, sel=1, branch_target=32'h0000_2000 for 3 edges -> pc stays 32'h0000_0100 while next_pc=32'h0000_2000. Raising pc_en -> pc=32'h0000_2000 after 1 edge.
6. Misalignment: sel=1, branch_target=32'h0000_1002 -> next_pc_misaligned=1, and pc loads 32'h0000_1002 on the next enabled edge.

Source files
------------

// File: rtl/next_pc_mux_pkg.sv
// next_pc_mux_pkg: processor-wide address width, reset vector and PC-source select encoding
package next_pc_mux_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = '0;
  typedef enum logic {
    PC_SRC_SEQ    = 1'b0,
    PC_SRC_BRANCH = 1'b1
  } pc_src_e;
endpackage

// File: rtl/next_pc_mux_pc_reg.sv
// pc_reg: enable flop holding the architectural PC, asynchronously reset to the reset vector
module pc_reg #(
  parameter int W = 32,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= RESET_VAL;
    else if (en) q <= d;
endmodule

// File: rtl/next_pc_mux.sv
// next_pc_mux: selects PC+4 or the branch target as next PC and holds the PC register
module next_pc_mux #(
  parameter int XLEN = next_pc_mux_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = next_pc_mux_pkg::RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc_plus4,
  input  logic [XLEN-1:0] branch_target,
  input  logic            sel,
  input  logic            pc_en,
  output logic [XLEN-1:0] next_pc,
  output logic [XLEN-1:0] pc,
  output logic            next_pc_misaligned
);
  import next_pc_mux_pkg::*;
  assign next_pc = (pc_src_e'(sel) == PC_SRC_BRANCH) ? branch_target : pc_plus4;
  // misaligned targets still load; trapping is left to the control unit
  assign next_pc_misaligned = |next_pc[1:0];
  pc_reg #(.W(XLEN), .RESET_VAL(RESET_PC)) u_pc_reg (
    .clk(clk),
    .rst_n(rst_n),
    .en(pc_en),
    .d(next_pc),
    .q(pc)
  );
endmodule

// File: tb/tb_next_pc_mux.sv
// tb_next_pc_mux: directed vectors with a queued scoreboard checked by a negedge monitor
module tb_next_pc_mux;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_plus4 = '0;
  logic [31:0] branch_target = '0;
  logic        sel = 1'b0;
  logic        pc_en = 1'b0;
  logic [31:0] next_pc;
  logic [31:0] pc;
  logic        next_pc_misaligned;
  int checks = 0;
  int failures = 0;
  typedef struct {
    string       name;
    logic [31:0] np;
    logic        mis;
    logic [31:0] pc;
  } exp_t;
  exp_t sb[$];
  next_pc_mux dut (
    .clk(clk),
    .rst_n(rst_n),
    .pc_plus4(pc_plus4),
    .branch_target(branch_target),
    .sel(sel),
    .pc_en(pc_en),
    .next_pc(next_pc),
    .pc(pc),
    .next_pc_misaligned(next_pc_misaligned)
  );
  always #5 clk = ~clk;
  // inputs change 1ns after posedge; outputs are judged at the following negedge
  always @(negedge clk)
    while (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      checks += 3;
      if (next_pc !== e.np) begin
        failures++;
        $display("FAIL %s next_pc got=%h want=%h", e.name, next_pc, e.np);
      end
      if (next_pc_misaligned !== e.mis) begin
        failures++;
        $display("FAIL %s misaligned got=%b want=%b", e.name, next_pc_misaligned, e.mis);
      end
      if (pc !== e.pc) begin
        failures++;
        $display("FAIL %s pc got=%h want=%h", e.name, pc, e.pc);
      end
    end
  task automatic step(input string name, input logic r, input logic [31:0] p4, input logic [31:0] bt,
                      input logic s, input logic en, input logic [31:0] np, input logic mis,
                      input logic [31:0] epc);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = r;
    pc_plus4 = p4;
    branch_target = bt;
    sel = s;
    pc_en = en;
    e.name = name;
    e.np = np;
    e.mis = mis;
    e.pc = epc;
    sb.push_back(e);
  endtask
  initial begin
    step("reset_hold",   0, 32'h0000_0004, 32'h0000_1000, 0, 1, 32'h0000_0004, 0, 32'h0000_0000);
    step("reset_rel",    1, 32'h0000_0004, 32'h0000_1000, 0, 1, 32'h0000_0004, 0, 32'h0000_0000);
    step("first_load",   1, 32'h0000_0008, 32'h0000_1000, 1, 1, 32'h0000_1000, 0, 32'h0000_0004);
    step("backward",     1, 32'h0000_0204, 32'h0000_0100, 1, 1, 32'h0000_0100, 0, 32'h0000_1000);
    step("wide_seq",     1, 32'h0FFF_FFF4, 32'h0000_0000, 0, 1, 32'h0FFF_FFF4, 0, 32'h0000_0100);
    step("wide_br",      1, 32'h0000_0ABC, 32'h1000_0000, 1, 1, 32'h1000_0000, 0, 32'h0FFF_FFF4);
    step("br_zero",      1, 32'h0000_0ABC, 32'h0000_0000, 1, 1, 32'h0000_0000, 0, 32'h1000_0000);
    step("seq_zero",     1, 32'h0000_0000, 32'h0000_0500, 0, 1, 32'h0000_0000, 0, 32'h0000_0000);
    step("to_100",       1, 32'h0000_0100, 32'h0000_0000, 0, 1, 32'h0000_0100, 0, 32'h0000_0000);
    step("stall_set",    1, 32'h0000_0104, 32'h0000_2000, 1, 0, 32'h0000_2000, 0, 32'h0000_0100);
    step("stall_1",      1, 32'h0000_0104, 32'h0000_2000, 1, 0, 32'h0000_2000, 0, 32'h0000_0100);
    step("stall_2",      1, 32'h0000_0104, 32'h0000_2000, 1, 0, 32'h0000_2000, 0, 32'h0000_0100);
    step("stall_3",      1, 32'h0000_0104, 32'h0000_2000, 1, 0, 32'h0000_2000, 0, 32'h0000_0100);
    step("unstall",      1, 32'h0000_0104, 32'h0000_2000, 1, 1, 32'h0000_2000, 0, 32'h0000_0100);
    step("misalign",     1, 32'h0000_2004, 32'h0000_1002, 1, 1, 32'h0000_1002, 1, 32'h0000_2000);
    step("mis_load",     1, 32'h0000_1006, 32'h0000_0000, 0, 1, 32'h0000_1006, 1, 32'h0000_1002);
    step("mid_reset",    0, 32'h0000_0008, 32'h0000_0000, 0, 1, 32'h0000_0008, 0, 32'h0000_0000);
    step("mid_rel",      1, 32'h0000_0008, 32'h0000_0000, 0, 1, 32'h0000_0008, 0, 32'h0000_0000);
    step("post_reset",   1, 32'h0000_000C, 32'h0000_0000, 0, 1, 32'h0000_000C, 0, 32'h0000_0008);
    repeat (2) @(posedge clk);
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
